adc_sar_readout: RTL and testbench
==================================

// Module: adc_sar_readout
// PURPOSE
// - Digital-side controller and reader for the 10-bit SAR ADC logic block; drives its Samp input and captures B/BN at eoc.
// - Sequences sample -> convert -> capture and checks B/BN complementarity.
// - Optionally averages 2^AVG_LOG2 conversions per result.
// - Delivers results through a small FIFO with a valid/ready handshake to the user-area bus logic.
// PARAMETERS
// NBITS        10  ADC resolution (width of adc_b/adc_bn)
// SAMP_CYCLES  2   clk cycles adc_samp is held high per conversion (>=1)
// CONV_TIMEOUT 20  clk cycles allowed from adc_samp fall to synchronized eoc rise
// AVG_LOG2     0   log2 of conversions averaged per output word (0..4)
// FIFO_DEPTH   4   result FIFO entries (power of 2, >=2)
// PORTS
// clk        in   1      system clock, also clocks the ADC logic block
// rst        in   1      synchronous active-high reset
// en         in   1      1 = convert continuously; 0 = finish current conversion, then idle
// adc_eoc    in   1      end-of-conversion from ADC (async to this domain)
// adc_b      in   NBITS  ADC result bits
// adc_bn     in   NBITS  ADC complementary result bits
// adc_samp   out  1      sample/reset command to ADC, active high
// dout       out  NBITS  result word (FIFO head)
// dout_valid out  1      dout holds a valid result
// dout_ready in   1      consumer accepts dout when valid&ready at posedge clk
// ovf        out  1      sticky: result dropped because FIFO full
// cmp_err    out  1      sticky: some captured adc_b != ~adc_bn
// tmo_err    out  1      sticky: eoc not seen within CONV_TIMEOUT
// err_clr    in   1      clears ovf, cmp_err, tmo_err (one-cycle pulse)
// BEHAVIOUR
// - Reset: adc_samp=1 (ADC held in sample/reset), dout_valid=0, dout=0, ovf=cmp_err=tmo_err=0.
//   FIFO emptied, accumulator and average counter cleared, FSM in IDLE.
// - adc_eoc passes through a 2-flop synchronizer; eoc_rise = sync & ~sync_d. All eoc use is via eoc_rise.
// - FSM IDLE: adc_samp=1. en=1 -> SAMPLE.
// - FSM SAMPLE: adc_samp=1 for exactly SAMP_CYCLES cycles, then -> CONVERT with adc_samp=0.
// - FSM CONVERT: adc_samp=0; timeout counter runs.
//   - eoc_rise -> CAPTURE.
//   - Counter reaching CONV_TIMEOUT -> set tmo_err, discard sample, -> SAMPLE if en else IDLE.
// - FSM CAPTURE (1 cycle): register adc_b.
//   - If adc_b != ~adc_bn, set cmp_err; the word is still used.
//   - Add the word to the accumulator (NBITS+AVG_LOG2 bits, never overflows) and increment the average count.
//   - When count == 2^AVG_LOG2: push acc>>AVG_LOG2 (truncate), clear acc and count.
//   - Next state: SAMPLE if en else IDLE.
// - en deassert mid-conversion: the conversion completes and its capture is used. A partial average is kept until en returns.
// - With AVG_LOG2=0, every capture pushes one word.
// - Latency: SAMPLE entry to CAPTURE = SAMP_CYCLES + ADC conversion (12 clk) + 2 sync cycles + 1.
//   The pushed word is visible on dout one cycle after CAPTURE.
// - FIFO full on push: push dropped, ovf set.
//   Simultaneous push and pop when full: both occur, no ovf.
// - FIFO empty: dout_valid=0, dout holds last value.
//   Pop only on dout_valid & dout_ready.
// - Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
// - err_clr in the same cycle as a new error event: the set wins.
// - rst at any state returns to IDLE next cycle with adc_samp=1. An in-flight conversion is abandoned and not pushed.
// STRUCTURE
// - Package adc_sar_pkg: NBITS default, FSM state enum (IDLE, SAMPLE, CONVERT, CAPTURE), ADC_CONV_CLKS=12.
// - Sub-module sar_result_fifo: sync FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty.
// - Top file holds the synchronizer, FSM, timeout counter, accumulator and sticky flags.
// TESTING
// - Behavioural ADC model returns a fixed code 12 clk after adc_samp falls.
// 1. Reset then en=1, ADC code 0x2A5, dout_ready=1 -> dout=0x2A5, dout_valid 1 cycle, repeats every conversion period.
// 2. AVG_LOG2=2, codes 100,101,102,104 -> single word 101 (407>>2). No output after the first 3 captures.
// 3. dout_ready=0, 5 conversions, FIFO_DEPTH=4 -> 4 words held in order, ovf=1.
//    Then err_clr -> ovf=0. Then drain: 4 words out, dout_valid=0.
// 4. Model never raises eoc -> tmo_err=1 after CONV_TIMEOUT cycles in CONVERT, FSM re-enters SAMPLE, nothing pushed.
// 5. Model drives adc_bn=adc_b (0x155) -> cmp_err=1, word 0x155 still delivered.
// 6. rst asserted mid-CONVERT -> next cycle adc_samp=1, FIFO empty, flags 0, no stale word after release.

Source files
------------

// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared constants and FSM state type for the SAR ADC readout
package adc_sar_pkg;
    localparam int NBITS_DEF = 10;
    localparam int ADC_CONV_CLKS = 12;
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, CAPTURE} state_e;
endpackage

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: synchronous result FIFO; extra pointer bit separates full from empty
module sar_result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    assign empty = wr_q == rd_q;
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // when empty, dout keeps showing the most recently consumed word
    assign dout = empty ? last_q : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                last_q <= mem_q[rd_q[AW-1:0]];
                rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/adc_sar_readout.sv
// adc_sar_readout: sequences the SAR ADC, checks B/BN, averages and queues results
module adc_sar_readout
    import adc_sar_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int SAMP_CYCLES = 2,
    parameter int CONV_TIMEOUT = 20,
    parameter int AVG_LOG2 = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             adc_eoc,
    input  logic [NBITS-1:0] adc_b,
    input  logic [NBITS-1:0] adc_bn,
    output logic             adc_samp,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
    output logic             cmp_err,
    output logic             tmo_err,
    input  logic             err_clr
);
    localparam int AW = NBITS + AVG_LOG2;
    localparam int CMAX = SAMP_CYCLES > CONV_TIMEOUT ? SAMP_CYCLES : CONV_TIMEOUT;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [AVG_LOG2:0] avg_q, avg_d;
    logic [2:0] eoc_q;
    logic ovf_q, ovf_d, cmp_q, cmp_d, tmo_q, tmo_d;
    logic eoc_rise, last, push, full, empty;
    assign eoc_rise = eoc_q[1] & ~eoc_q[2];
    assign sum = acc_q + AW'(adc_b);
    assign last = avg_q == AVG_LAST;
    assign push = state_q == CAPTURE && last;
    assign adc_samp = state_q == IDLE || state_q == SAMPLE;
    assign dout_valid = !empty;
    assign ovf = ovf_q;
    assign cmp_err = cmp_q;
    assign tmo_err = tmo_q;
    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        acc_d = acc_q;
        avg_d = avg_q;
        cmp_d = cmp_q & ~err_clr;
        tmo_d = tmo_q & ~err_clr;
        ovf_d = (ovf_q & ~err_clr) | (push & full & ~(dout_valid & dout_ready));
        case (state_q)
            IDLE: state_d = en ? SAMPLE : IDLE;
            SAMPLE: begin
                if (cnt_q == CW'(SAMP_CYCLES - 1)) state_d = CONVERT;
                else cnt_d = cnt_q + 1'b1;
            end
            CONVERT: begin
                if (eoc_rise) state_d = CAPTURE;
                else if (cnt_q == CW'(CONV_TIMEOUT - 1)) begin
                    tmo_d = 1'b1;
                    state_d = en ? SAMPLE : IDLE;
                end else cnt_d = cnt_q + 1'b1;
            end
            CAPTURE: begin
                cmp_d = cmp_d | (adc_b != ~adc_bn);
                acc_d = last ? '0 : sum;
                avg_d = last ? '0 : avg_q + 1'b1;
                state_d = en ? SAMPLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            avg_q <= '0;
            eoc_q <= '0;
            ovf_q <= 1'b0;
            cmp_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            avg_q <= avg_d;
            eoc_q <= {eoc_q[1:0], adc_eoc};
            ovf_q <= ovf_d;
            cmp_q <= cmp_d;
            tmo_q <= tmo_d;
        end
    end
    sar_result_fifo #(.WIDTH(NBITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(NBITS'(sum >> AVG_LOG2)),
        .pop(dout_valid & dout_ready),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_adc_sar_readout.sv
// tb_adc_sar_readout: randomized scoreboard bench with behavioural ADC models
module tb_adc_sar_readout;
    import adc_sar_pkg::*;
    localparam int NB = 10;
    localparam int DEPTH = 4;
    localparam int SAMP = 2;
    localparam int TMO = 20;
    localparam int PERIOD = SAMP + ADC_CONV_CLKS + 2 + 1 + 1;
    logic clk = 0, rst = 1, rst2 = 1;
    logic en = 0, eoc = 0, samp, dv, rdy = 0, ovf, cmp, tmo, clr = 0;
    logic [NB-1:0] b = 0, bn = 0, dout;
    logic en2 = 0, eoc2 = 0, samp2, dv2, rdy2 = 0, ovf2, cmp2, tmo2;
    logic [NB-1:0] b2 = 0, bn2 = 0, dout2;
    int tests = 0, fails = 0, cyc = 0;
    int mcnt = 0, mcnt2 = 0, eoc_count = 0, nb2 = 0, first_b = -1;
    logic no_eoc = 0, bad = 0, use_fixed = 0;
    logic [NB-1:0] fixed_code = 0, last_a = 0, last_exp = 0;
    logic exp_ovf = 0, exp_cmp = 0;
    logic [NB-1:0] exp_q[$], exp2[$], grp[$];
    logic [NB-1:0] tbl [4] = '{10'd100, 10'd101, 10'd102, 10'd104};
    int hs_t[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    adc_sar_readout #(.NBITS(NB), .SAMP_CYCLES(SAMP), .CONV_TIMEOUT(TMO), .AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .adc_eoc(eoc), .adc_b(b), .adc_bn(bn), .adc_samp(samp),
        .dout(dout), .dout_valid(dv), .dout_ready(rdy), .ovf(ovf), .cmp_err(cmp), .tmo_err(tmo), .err_clr(clr));
    adc_sar_readout #(.NBITS(NB), .SAMP_CYCLES(SAMP), .CONV_TIMEOUT(TMO), .AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u_avg (
        .clk(clk), .rst(rst2), .en(en2), .adc_eoc(eoc2), .adc_b(b2), .adc_bn(bn2), .adc_samp(samp2),
        .dout(dout2), .dout_valid(dv2), .dout_ready(rdy2), .ovf(ovf2), .cmp_err(cmp2), .tmo_err(tmo2), .err_clr(1'b0));
    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic expired(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask
    // ADC models: a code appears 12 clocks after samp falls; expectations are queued at that moment
    always @(posedge clk) begin : adc_a
        logic [NB-1:0] c;
        if (samp === 1'b1) begin
            eoc <= 0;
            mcnt <= 0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == ADC_CONV_CLKS - 1 && !no_eoc) begin
                c = use_fixed ? fixed_code : NB'($urandom_range(0, 1023));
                eoc <= 1;
                b <= c;
                bn <= bad ? c : ~c;
                eoc_count++;
                if (bad) exp_cmp = 1;
                if (exp_q.size() >= DEPTH) exp_ovf = 1;
                else exp_q.push_back(c);
            end
        end
    end
    always @(posedge clk) begin : adc_b_model
        logic [NB-1:0] c;
        int s;
        if (samp2 === 1'b1) begin
            eoc2 <= 0;
            mcnt2 <= 0;
        end else begin
            mcnt2 <= mcnt2 + 1;
            if (mcnt2 == ADC_CONV_CLKS - 1) begin
                c = nb2 < 4 ? tbl[nb2] : NB'($urandom_range(0, 1023));
                nb2++;
                eoc2 <= 1;
                b2 <= c;
                bn2 <= ~c;
                grp.push_back(c);
                if (grp.size() == 4) begin
                    s = 0;
                    foreach (grp[i]) s += int'(grp[i]);
                    exp2.push_back(NB'(s / 4));
                    grp.delete();
                end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && dv && rdy) begin
            hs_t.push_back(cyc);
            last_a = dout;
            if (exp_q.size() == 0) chk("dout_a_unexpected", int'(dout), -1);
            else begin
                last_exp = exp_q.pop_front();
                chk("dout_a", int'(dout), int'(last_exp));
            end
        end
        if (!rst2 && dv2 && rdy2) begin
            if (first_b < 0) first_b = int'(dout2);
            if (exp2.size() == 0) chk("dout_avg_unexpected", int'(dout2), -1);
            else chk("dout_avg", int'(dout2), int'(exp2.pop_front()));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_eocs(input int n);
        int t0 = eoc_count;
        for (int i = 0; i < 600 && eoc_count < t0 + n; i++) tick();
        if (eoc_count < t0 + n) expired("eoc_wait");
    endtask
    task automatic wait_hs(input int n);
        for (int i = 0; i < 600 && hs_t.size() < n; i++) tick();
        if (hs_t.size() < n) expired("handshake_wait");
    endtask
    task automatic wait_idle(input bit need_empty);
        int run = 0;
        for (int i = 0; i < 400 && run < 4; i++) begin
            tick();
            run = (samp && (!need_empty || (!dv && exp_q.size() == 0))) ? run + 1 : 0;
        end
        if (run < 4) expired("idle_wait");
    endtask
    task automatic pulse_clr();
        clr = 1;
        tick();
        clr = 0;
        tick();
    endtask
    initial begin
        int low, n0;
        repeat (3) tick();
        chk("rst_samp", samp, 1);
        chk("rst_valid", dv, 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cmp", cmp, 0);
        chk("rst_tmo", tmo, 0);
        rst = 0;
        rst2 = 0;
        en2 = 1;
        rdy2 = 1;
        tick();
        chk("idle_samp", samp, 1);
        fixed_code = 10'h2A5;
        use_fixed = 1;
        rdy = 1;
        en = 1;
        wait_hs(3);
        chk("one_cycle_valid", dv, 0);
        if (hs_t.size() >= 3) begin
            chk("period_1", hs_t[1] - hs_t[0], PERIOD);
            chk("period_2", hs_t[2] - hs_t[1], PERIOD);
        end
        use_fixed = 0;
        wait_hs(8);
        en = 0;
        wait_idle(1);
        rdy = 0;
        en = 1;
        wait_eocs(5);
        en = 0;
        wait_idle(0);
        chk("ovf_set", ovf, exp_ovf);
        chk("full_valid", dv, 1);
        chk("full_head", int'(dout), exp_q.size() > 0 ? int'(exp_q[0]) : -1);
        pulse_clr();
        exp_ovf = 0;
        chk("ovf_clr", ovf, 0);
        n0 = hs_t.size();
        rdy = 1;
        wait_idle(1);
        chk("drain_count", hs_t.size() - n0, DEPTH);
        chk("drain_valid", dv, 0);
        chk("dout_hold", int'(dout), int'(last_exp));
        no_eoc = 1;
        en = 1;
        low = 0;
        for (int i = 0; i < 200 && !tmo; i++) begin
            tick();
            if (!samp) low++;
        end
        chk("tmo_err", tmo, 1);
        chk("tmo_cycles", low, TMO);
        chk("tmo_resample", samp, 1);
        no_eoc = 0;
        en = 0;
        wait_idle(1);
        chk("tmo_sticky", tmo, 1);
        pulse_clr();
        chk("tmo_clr", tmo, 0);
        bad = 1;
        use_fixed = 1;
        fixed_code = 10'h155;
        en = 1;
        wait_eocs(1);
        en = 0;
        bad = 0;
        wait_idle(1);
        chk("cmp_err", cmp, exp_cmp);
        chk("cmp_word", int'(last_a), 'h155);
        use_fixed = 0;
        rdy = 0;
        en = 1;
        wait_eocs(1);
        for (int i = 0; i < 100 && !samp; i++) tick();
        for (int i = 0; i < 100 && samp; i++) tick();
        repeat (4) tick();
        chk("pre_rst_convert", samp, 0);
        rst = 1;
        en = 0;
        tick();
        exp_q.delete();
        exp_ovf = 0;
        exp_cmp = 0;
        chk("mid_rst_samp", samp, 1);
        chk("mid_rst_valid", dv, 0);
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_flags", {ovf, cmp, tmo}, 0);
        rst = 0;
        rdy = 1;
        repeat (30) tick();
        chk("no_stale", dv, 0);
        en = 1;
        n0 = hs_t.size();
        wait_hs(n0 + 2);
        en = 0;
        wait_idle(1);
        en2 = 0;
        low = 0;
        for (int i = 0; i < 400 && low < 4; i++) begin
            tick();
            low = (samp2 && !dv2) ? low + 1 : 0;
        end
        chk("avg_idle", low, 4);
        chk("avg_first", first_b, 101);
        chk("avg_drained", exp2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
